// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch sequencer.
//   seq_state_e          : sequencer states (FETCH, EXEC, HALTED)
//   JSEL_*               : jump_sel encodings
//   DEFAULT_RESET_VECTOR : default PC after reset
//   branch_offset()      : sign-extended, word-scaled 16-bit branch offset
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } seq_state_e;

  localparam logic [1:0] JSEL_NONE = 2'b00;
  localparam logic [1:0] JSEL_REG  = 2'b01;
  localparam logic [1:0] JSEL_PAGE = 2'b10;
  localparam logic [1:0] JSEL_REL  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational jump/branch target computation.
//   pc          : address of the instruction in EXEC
//   jump_sel    : 00 none, 01 register, 10 page, 11 PC-relative
//   rs_value    : register target
//   instr_index : J/JAL index field
//   imm16       : branch offset field (words, signed)
//   target      : computed target, modulo 2^32 (0 when jump_sel = none)
module pc_target_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] rs_value,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm16,
  output logic [31:0] target
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    target = 32'h0;
    case (jump_sel)
      JSEL_REG:  target = rs_value;
      // Page jumps stay within the 256 MB region of the delay-slot address.
      JSEL_PAGE: target = {pc_plus4[31:28], instr_index, 2'b00};
      JSEL_REL:  target = pc_plus4 + branch_offset(imm16);
      default:   target = 32'h0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a one-instruction branch delay slot.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | waiting for instruction memory; leaves when stall = 0
//   EXEC   | computes the target, applies any older pending target
//   HALTED | a zero (or misaligned) target was applied; frozen to reset
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   stall       : instruction memory not ready (sampled in FETCH only)
//   jump_sel    : jump type (sampled in EXEC only)
//   rs_value, instr_index, imm16 : target operands
//   state       : 0 = FETCH, 1 = EXEC (reads 0 while halted)
//   pc          : current instruction address
//   link_addr   : pc + 8
//   active      : low once halted
//   addr_error  : only with PC_SEQ_ALIGN_CHECK_EN; set when a misaligned
//                 target is applied
//
// Build option: PC_SEQ_ALIGN_CHECK_EN adds the alignment check and the
// addr_error port; without it targets are applied unmodified.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] rs_value,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm16,
  output logic        state,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        active
`ifdef PC_SEQ_ALIGN_CHECK_EN
  ,
  output logic        addr_error
`endif
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] target;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic addr_error_q, addr_error_d;
`endif

  pc_target_calc u_target_calc (
    .pc          (pc_q),
    .jump_sel    (jump_sel),
    .rs_value    (rs_value),
    .instr_index (instr_index),
    .imm16       (imm16),
    .target      (target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      addr_error_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      addr_error_q  <= addr_error_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    addr_error_d  = addr_error_q;
`endif
    case (state_q)
      FETCH: begin
        if (!stall) state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        // The older pending target is applied first; a branch in the
        // delay slot is then latched and takes effect one instruction later.
        if (pend_valid_q) begin
          pc_d         = pend_target_q;
          pend_valid_d = 1'b0;
          if (pend_target_q == 32'h0) state_d = HALTED;
`ifdef PC_SEQ_ALIGN_CHECK_EN
          if (pend_target_q[1:0] != 2'b00) begin
            state_d      = HALTED;
            addr_error_d = 1'b1;
          end
`endif
        end else begin
          pc_d = pc_q + 32'd4;
        end
        if (jump_sel != JSEL_NONE) begin
          pend_valid_d  = 1'b1;
          pend_target_d = target;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign state     = (state_q == EXEC);
  assign pc        = pc_q;
  assign link_addr = pc_q + 32'd8;
  assign active    = (state_q != HALTED);
`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign addr_error = addr_error_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes the expected
// post-edge outputs for each vector; the monitor pops and compares one
// entry after every rising edge.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  jump_sel;
  logic [31:0] rs_value;
  logic [25:0] instr_index;
  logic [15:0] imm16;
  logic        state;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        active;
  logic        addr_error_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st;
    logic [31:0] pc;
    logic        act;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .jump_sel    (jump_sel),
    .rs_value    (rs_value),
    .instr_index (instr_index),
    .imm16       (imm16),
    .state       (state),
    .pc          (pc),
    .link_addr   (link_addr),
    .active      (active)
`ifdef PC_SEQ_ALIGN_CHECK_EN
    ,
    .addr_error  (addr_error_w)
`endif
  );

`ifndef PC_SEQ_ALIGN_CHECK_EN
  assign addr_error_w = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic r, input logic s, input logic [1:0] js,
                      input logic [31:0] rs, input logic [25:0] idx,
                      input logic [15:0] imm, input logic es,
                      input logic [31:0] ep, input logic ea, input logic ee);
    exp_t e;
    @(negedge clk);
    reset       = r;
    stall       = s;
    jump_sel    = js;
    rs_value    = rs;
    instr_index = idx;
    imm16       = imm;
    e.st  = es;
    e.pc  = ep;
    e.act = ea;
    e.err = ee;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic es, input logic [31:0] ep);
    step(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, es, ep, 1'b1, 1'b0);
  endtask

  task automatic jmp(input logic [1:0] js, input logic [31:0] rs,
                     input logic [25:0] idx, input logic [15:0] imm,
                     input logic es, input logic [31:0] ep);
    step(1'b0, 1'b0, js, rs, idx, imm, es, ep, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input logic s);
    step(1'b1, s, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'hBFC0_0000, 1'b1, 1'b0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL state: got %0b expected %0b (t=%0t)", state, e.st, $time);
        end
        checks++;
        if (pc !== e.pc) begin
          errors++;
          $display("FAIL pc: got %08h expected %08h (t=%0t)", pc, e.pc, $time);
        end
        checks++;
        if (active !== e.act) begin
          errors++;
          $display("FAIL active: got %0b expected %0b (t=%0t)", active, e.act, $time);
        end
        checks++;
        if (link_addr !== e.pc + 32'd8) begin
          errors++;
          $display("FAIL link_addr: got %08h expected %08h (t=%0t)",
                   link_addr, e.pc + 32'd8, $time);
        end
        checks++;
        if (addr_error_w !== e.err) begin
          errors++;
          $display("FAIL addr_error: got %0b expected %0b (t=%0t)",
                   addr_error_w, e.err, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; jump_sel = 2'b00;
    rs_value = 32'h0; instr_index = 26'h0; imm16 = 16'h0;

    // Reset, free-running fetch/exec, stalls
    do_reset(1'b0);
    idle(1'b1, 32'hBFC0_0000);
    idle(1'b0, 32'hBFC0_0004);
    repeat (3) step(1'b0, 1'b1, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'hBFC0_0004, 1'b1, 1'b0);
    idle(1'b1, 32'hBFC0_0004);
    step(1'b0, 1'b1, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'hBFC0_0008, 1'b1, 1'b0);
    idle(1'b1, 32'hBFC0_0008);
    idle(1'b0, 32'hBFC0_000C);
    idle(1'b1, 32'hBFC0_000C);
    idle(1'b0, 32'hBFC0_0010);
    // jump_sel in FETCH must be ignored
    jmp(2'b01, 32'h0, 26'h0, 16'h0, 1'b1, 32'hBFC0_0010);
    // PC-relative backwards branch
    jmp(2'b11, 32'h0, 26'h0, 16'hFFFE, 1'b0, 32'hBFC0_0014);
    idle(1'b1, 32'hBFC0_0014);
    idle(1'b0, 32'hBFC0_000C);

    // Page jump
    do_reset(1'b0);
    idle(1'b1, 32'hBFC0_0000);
    jmp(2'b10, 32'h0, 26'h000_0040, 16'h0, 1'b0, 32'hBFC0_0004);
    idle(1'b1, 32'hBFC0_0004);
    idle(1'b0, 32'hB000_0100);
    // Branch in the delay slot of a branch
    idle(1'b1, 32'hB000_0100);
    jmp(2'b11, 32'h0, 26'h0, 16'h0004, 1'b0, 32'hB000_0104);
    idle(1'b1, 32'hB000_0104);
    jmp(2'b11, 32'h0, 26'h0, 16'h0100, 1'b0, 32'hB000_0114);
    idle(1'b1, 32'hB000_0114);
    idle(1'b0, 32'hB000_0508);
    // Register jump to zero halts
    idle(1'b1, 32'hB000_0508);
    jmp(2'b01, 32'h0, 26'h0, 16'h0, 1'b0, 32'hB000_050C);
    idle(1'b1, 32'hB000_050C);
    step(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b01, 32'h1234, 26'h3, 16'h5, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b11, 32'h0, 26'h0, 16'hFFFF, 1'b0, 32'h0, 1'b0, 1'b0);
    do_reset(1'b0);

    // Pending branch discarded by reset during a stall
    idle(1'b1, 32'hBFC0_0000);
    jmp(2'b10, 32'h0, 26'h000_0040, 16'h0, 1'b0, 32'hBFC0_0004);
    step(1'b0, 1'b1, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'hBFC0_0004, 1'b1, 1'b0);
    do_reset(1'b1);
    idle(1'b1, 32'hBFC0_0000);
    idle(1'b0, 32'hBFC0_0004);
    idle(1'b1, 32'hBFC0_0004);
    idle(1'b0, 32'hBFC0_0008);

    // pc+4 wraps to zero without halting
    idle(1'b1, 32'hBFC0_0008);
    jmp(2'b01, 32'hFFFF_FFFC, 26'h0, 16'h0, 1'b0, 32'hBFC0_000C);
    idle(1'b1, 32'hBFC0_000C);
    idle(1'b0, 32'hFFFF_FFFC);
    idle(1'b1, 32'hFFFF_FFFC);
    idle(1'b0, 32'h0000_0000);
    idle(1'b1, 32'h0000_0000);
    idle(1'b0, 32'h0000_0004);

    // Misaligned register target
    idle(1'b1, 32'h0000_0004);
    jmp(2'b01, 32'hBFC0_0002, 26'h0, 16'h0, 1'b0, 32'h0000_0008);
    idle(1'b1, 32'h0000_0008);
`ifdef PC_SEQ_ALIGN_CHECK_EN
    step(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'hBFC0_0002, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'b01, 32'h8, 26'h0, 16'h0, 1'b0, 32'hBFC0_0002, 1'b0, 1'b1);
    do_reset(1'b0);
`else
    idle(1'b0, 32'hBFC0_0002);
    idle(1'b1, 32'hBFC0_0002);
    idle(1'b0, 32'hBFC0_0006);
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port stall, input, 1, instruction memory not ready; holds FETCH.
REQ-005 SHALL have port jump_sel, input, 2, encoding 00 none, 01 register, 10 page, 11 PC-relative; sampled in EXEC.
REQ-006 SHALL have port rs_value, input, 32, register target for jump_sel=01.
REQ-007 SHALL have port instr_index, input, 26, J/JAL index field.
REQ-008 SHALL have port imm16, input, 16, branch offset field.
REQ-009 SHALL have port state, output, 1, 0=FETCH, 1=EXEC.
REQ-010 SHALL have port pc, output, 32, address of the current instruction.
REQ-011 SHALL have port link_addr, output, 32, pc+8, always valid.
REQ-012 SHALL have port active, output, 1, high until halt.

Function
REQ-013 SHALL implement three states: FETCH, EXEC, HALTED.
REQ-014 SHALL go FETCH->EXEC on a clock where stall=0; SHALL stay in FETCH while stall=1.
REQ-015 SHALL go EXEC->FETCH unconditionally, except EXEC->HALTED as in REQ-020.
REQ-016 SHALL compute the target in EXEC: 01 -> rs_value; 10 -> {(pc+4)[31:28], instr_index, 2'b00}; 11 -> pc+4+(sign-extended imm16 << 2); all modulo 2^32.
REQ-017 SHALL, when jump_sel!=00 in EXEC, latch the target and set pending_valid; the target is not applied in that EXEC.
REQ-018 SHALL update pc at the end of each EXEC: if pending_valid was set before this EXEC, pc <= pending target and pending_valid clears; otherwise pc <= pc+4. This is a one-instruction branch delay slot.
REQ-019 SHALL, when the delay-slot instruction itself has jump_sel!=00, apply the old pending target and then latch the new target as pending; the new branch wins one instruction later.
REQ-020 SHALL, when the target being applied equals 32'h0, enter HALTED instead of FETCH and drive active=0.
REQ-021 SHALL hold pc, state and pending in HALTED until reset; all inputs are ignored.
REQ-022 SHALL ignore jump_sel and stall outside the states in which they are sampled.
REQ-023 SHALL wrap pc+4 from 32'hFFFFFFFC to 32'h0 with no error.

Reset
REQ-024 SHALL on reset=1 at a clock edge set pc=RESET_VECTOR, state=FETCH, active=1, pending_valid=0, pending target=0.
REQ-025 SHALL let reset override all other inputs in every state, including HALTED and mid-stall; a pending branch is discarded.

Configuration
REQ-026 SHALL honour macro PC_SEQ_ALIGN_CHECK_EN: when defined, add output addr_error (1 bit, reset 0); a target with bits [1:0]!=0 SHALL set addr_error=1 and enter HALTED when applied; when undefined there is no such port and targets are used unmodified.

Structure
REQ-027 SHALL take from shared package cpu_pkg: the state enum (FETCH, EXEC, HALTED), the jump_sel encodings, and the default RESET_VECTOR constant.
REQ-028 SHALL contain the combinational sub-module pc_target_calc (inputs: pc, jump_sel, rs_value, instr_index, imm16; output: target).

Verification
REQ-029 SHALL cover reset then no stall: pc=BFC00000 in FETCH, then EXEC, then pc=BFC00004; state toggles each cycle.
REQ-030 SHALL cover stall=1 for 3 cycles in FETCH: state stays 0 and pc stays constant; EXEC follows the first stall=0 cycle.
REQ-031 SHALL cover pc=BFC00010 with jump_sel=11 and imm16=FFFE in EXEC: next pc=BFC00014 (delay slot), then pc=BFC0000C.
REQ-032 SHALL cover pc=BFC00000 with jump_sel=10 and instr_index=0000040: delay slot at BFC00004, then pc=B0000100.
REQ-033 SHALL cover jump_sel=01 with rs_value=0: after the delay slot active=0, state=HALTED, and pc is frozen; reset restores BFC00000 and active=1.
REQ-034 SHALL cover, with PC_SEQ_ALIGN_CHECK_EN defined, jump_sel=01 with rs_value=BFC00002: after the delay slot addr_error=1 and the block halts.
